dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WORDS, default 64: number of data-memory words; word address range 0..ADDR_WORDS-1.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 p0_valid  input  1  port 0 (core load/store) request pending.
REQ-005 p0_we  input  1  port 0 request type; 1 = write, 0 = read.
REQ-006 p0_addr  input  32  port 0 word address.
REQ-007 p0_wdata  input  32  port 0 write data.
REQ-008 p0_ready  output  1  port 0 request accepted this cycle.
REQ-009 p0_rsp_valid  output  1  port 0 response strobe, one cycle.
REQ-010 p0_rsp_rdata  output  32  port 0 read data, valid with p0_rsp_valid.
REQ-011 p0_rsp_err  output  1  port 0 address out of range, valid with p0_rsp_valid.
REQ-012 p1_valid, p1_we, p1_addr, p1_wdata, p1_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err: port 1 (debug/loader), same directions, widths and meanings as port 0.
REQ-013 mem_read  output  1  data-memory read enable.
REQ-014 mem_write  output  1  data-memory write enable.
REQ-015 mem_addr  output  32  data-memory word address.
REQ-016 mem_wdata  output  32  data-memory write data.
REQ-017 mem_rdata  input  32  data-memory combinational read data.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS on accept; ACCESS->RESP always; RESP->IDLE always.
REQ-019 Accept only in IDLE: exactly one pN_ready high, combinationally, for the granted port when its pN_valid is high; both ready low in ACCESS and RESP.
REQ-020 Accepted port index, we, addr and wdata latched at the accept edge; later port input changes ignored until the next accept.
REQ-021 Arbitration round-robin: when both valid, grant the port not granted last; a single valid port always wins.
REQ-022 last_grant resets to 1, so port 0 wins the first contention.
REQ-023 ACCESS, in-range address (addr < ADDR_WORDS): mem_read = !we, mem_write = we, mem_addr = latched addr, mem_wdata = latched wdata, for exactly one cycle.
REQ-024 ACCESS, out-of-range address: mem_read = mem_write = 0; error flag latched.
REQ-025 Read data captured from mem_rdata at the ACCESS->RESP edge; writes return rdata = 0.
REQ-026 RESP: rsp_valid high one cycle on the granted port only, with rdata and err; other port's rsp outputs 0.
REQ-027 Latency: accept at cycle T, memory access T+1, response T+2, next accept no earlier than T+3.
REQ-028 Outside ACCESS: mem_read, mem_write = 0, mem_addr, mem_wdata = 0.
REQ-029 A valid deasserted before being granted is dropped without side effects.

Reset
REQ-030 rst asserted: state = IDLE, last_grant = 1, all latched fields 0, all outputs 0 (ready, rsp_valid, rsp_rdata, rsp_err, mem_*), asynchronously.
REQ-031 rst mid-ACCESS aborts the access: no response issued; a write whose commit edge coincides with rst is not guaranteed.
REQ-032 First accept possible in the first cycle after rst deasserts.

Structure
REQ-033 Shared package dmem_arb_pkg: state enum (IDLE, ACCESS, RESP), ADDR_WORDS default, port-index type.
REQ-034 Sub-module rr_arb2: two-requester round-robin arbiter (req[1:0], last_grant -> grant one-hot), combinational.

Verification
REQ-035 Single read: p0 reads addr 17 with memory holding 56 -> p0_ready at T, mem_read at T+1, p0_rsp_valid, p0_rsp_rdata = 56 at T+2.
REQ-036 Write then read: p1 writes 0xDEADBEEF to addr 5, then reads addr 5 -> mem_write one cycle, then p1_rsp_rdata = 0xDEADBEEF.
REQ-037 Contention: p0 and p1 valid continuously after reset -> grants p0, p1, p0, p1, 3 cycles apart.
REQ-038 Out of range: p0 reads addr 64 -> no mem_read/mem_write, p0_rsp_err = 1, rdata = 0.
REQ-039 Input hold: p0 changes addr from 3 to 9 after accept -> access and response use addr 3.
REQ-040 Reset mid-ACCESS: rst during write to addr 2 -> no rsp_valid, all outputs 0, next p0 accept succeeds after rst deasserts.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   state_t     : arbiter FSM states (IDLE, ACCESS, RESP)
//   port_idx_t  : index of a requesting port (0 = core, 1 = debug/loader)
//   req_t       : one captured request (port, type, address, write data)
//   ADDR_WORDS_DEFAULT : default data-memory depth in words
package dmem_arb_pkg;

  localparam int ADDR_WORDS_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef logic port_idx_t;

  typedef struct packed {
    port_idx_t   port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port.
//   pN_valid/we/addr/wdata : request from port N
//   pN_ready               : request accepted this cycle
//   pN_rsp_valid/rdata/err : one-cycle response to port N
//   mem_read/write/addr/wdata, mem_rdata : single data-memory port
// slave  : the arbiter side
// master : the requesters plus the memory (e.g. a testbench)
interface dmem_arbiter_if;

  logic        p0_valid;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_ready;
  logic        p0_rsp_valid;
  logic [31:0] p0_rsp_rdata;
  logic        p0_rsp_err;

  logic        p1_valid;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ready;
  logic        p1_rsp_valid;
  logic [31:0] p1_rsp_rdata;
  logic        p1_rsp_err;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata,
    output p0_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
    input  p1_valid, p1_we, p1_addr, p1_wdata,
    output p1_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata,
    input  p0_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
    output p1_valid, p1_we, p1_addr, p1_wdata,
    input  p1_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational.
//   req        : request vector {port1, port0}
//   last_grant : port granted most recently
//   grant      : one-hot grant (all zero when nothing is requested)
// A lone requester always wins; on contention the port that was not
// granted last wins.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  last_grant,
  output logic [1:0] grant
);

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || last_grant == 1'b1)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters (core load/store, debug/loader) onto one
// single-ported data memory. Each transaction takes three cycles:
// accept (IDLE), memory access (ACCESS), response (RESP).
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : requester ports and memory port (dmem_arbiter_if.slave)
// Addresses at or above ADDR_WORDS never reach the memory; they complete
// with the error flag set and zero read data.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WORDS = ADDR_WORDS_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  state_t      state_q, state_d;
  port_idx_t   last_grant_q;
  req_t        req_q, req_in;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [1:0]  grant;
  logic        accept;
  logic        in_range;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.p1_valid, bus.p0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign in_range = (req_q.addr < 32'(ADDR_WORDS));

  // Fields of whichever port the arbiter is granting this cycle.
  always_comb begin
    req_in.port  = grant[1];
    req_in.we    = grant[1] ? bus.p1_we    : bus.p0_we;
    req_in.addr  = grant[1] ? bus.p1_addr  : bus.p0_addr;
    req_in.wdata = grant[1] ? bus.p1_wdata : bus.p0_wdata;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      req_q        <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q        <= req_in;
        last_grant_q <= req_in.port;
      end
      if (state_q == ACCESS) begin
        err_q   <= !in_range;
        rdata_q <= (in_range && !req_q.we) ? bus.mem_rdata : '0;
      end
    end
  end

  always_comb begin
    bus.p0_ready     = 1'b0;
    bus.p1_ready     = 1'b0;
    bus.p0_rsp_valid = 1'b0;
    bus.p0_rsp_rdata = '0;
    bus.p0_rsp_err   = 1'b0;
    bus.p1_rsp_valid = 1'b0;
    bus.p1_rsp_rdata = '0;
    bus.p1_rsp_err   = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    unique case (state_q)
      IDLE: begin
        // Ready is masked by rst so it drops immediately on reset even
        // though a requester may still hold valid.
        bus.p0_ready = grant[0] && !rst;
        bus.p1_ready = grant[1] && !rst;
      end
      ACCESS: begin
        if (in_range) begin
          bus.mem_read  = !req_q.we;
          bus.mem_write = req_q.we;
          bus.mem_addr  = req_q.addr;
          bus.mem_wdata = req_q.wdata;
        end
      end
      RESP: begin
        if (req_q.port == 1'b0) begin
          bus.p0_rsp_valid = 1'b1;
          bus.p0_rsp_rdata = rdata_q;
          bus.p0_rsp_err   = err_q;
        end else begin
          bus.p1_rsp_valid = 1'b1;
          bus.p1_rsp_rdata = rdata_q;
          bus.p1_rsp_err   = err_q;
        end
      end
      default: ;
    endcase
  end

endmodule
